// File: rtl/dds_sample_recorder_if.sv
// Readout stream of the DDS sample recorder: one channel sample per beat, valid/ready handshake.
interface dds_sample_recorder_if #(
    parameter int SAMPLE_W = 12,
    parameter int CH_W     = 1
);
    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] out_data;
    logic [CH_W-1:0]     out_ch;
    logic                out_last;

    modport master (output out_valid, out_data, out_ch, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_ch, out_last, output out_ready);
endinterface

// File: rtl/dds_sample_recorder.sv
// Captures N consecutive multi-channel DDS sample words into on-chip RAM (immediate or ch0
// rising-crossing trigger), then streams them out one channel per beat over valid/ready.
module dds_sample_recorder #(
    parameter int SAMPLE_W   = 12,
    parameter int N_CH       = 2,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = 10,
    parameter int TRIG_LEVEL = 2048,
    parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     sample_stb,
    input  logic [N_CH*SAMPLE_W-1:0] sample_in,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     trig_mode,
    input  logic [ADDR_W:0]          n_samples,
    input  logic                     rd_start,
    dds_sample_recorder_if.master    rd,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W:0]          sample_count
);

    typedef logic [N_CH-1:0][SAMPLE_W-1:0] word_t;
    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE, S_READOUT} state_t;

    localparam logic [ADDR_W:0]     DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]     CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [SAMPLE_W-1:0] TRIG_C  = SAMPLE_W'(TRIG_LEVEL);
    localparam logic [CH_W-1:0]     LAST_CH = CH_W'(N_CH - 1);

    state_t              state;
    logic [ADDR_W:0]     n_lat;
    logic                mode_lat;
    logic [SAMPLE_W-1:0] prev_ch0;
    logic                prev_ok;

    logic [SAMPLE_W-1:0] ch0;
    logic [ADDR_W:0]     n_clamp;
    logic [ADDR_W:0]     cnt_inc;
    logic                trig_hit;
    logic                first_wr;
    logic                start_arm;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;

    word_t               mem [DEPTH];
    word_t               rd_word;
    logic                rd_en;
    logic [ADDR_W:0]     rd_ptr;
    logic                rd_pend;
    logic                rd_last_q;

    word_t               cur_word;
    word_t               nxt_word;
    logic                cur_valid;
    logic                nxt_valid;
    logic                cur_last;
    logic                nxt_last;
    logic [CH_W-1:0]     cur_ch;
    logic                hs;
    logic                word_pop;
    logic                finish;
    logic                flush;
    logic [1:0]          occ_next;

    assign ch0       = sample_in[SAMPLE_W-1:0];
    assign n_clamp   = (n_samples == '0 || n_samples > DEPTH_C) ? DEPTH_C : n_samples;
    assign cnt_inc   = sample_count + CNT_ONE;
    assign trig_hit  = prev_ok && (prev_ch0 < TRIG_C) && (ch0 >= TRIG_C);
    assign start_arm = arm && (state == S_IDLE || state == S_DONE);
    assign first_wr  = (state == S_ARMED) && sample_stb && (!mode_lat || trig_hit);

    // NOTE: every output of a combinational block gets a default first, so no path can leave it
    // holding its old value and infer a latch.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        if (!reset && !abort) begin
            if (first_wr) begin
                wr_en = 1'b1;
            end else if (state == S_CAPTURE && sample_stb) begin
                wr_en   = 1'b1;
                wr_addr = sample_count[ADDR_W-1:0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order or of other always_ff blocks.
    always_ff @(posedge sysclk) begin
        if (reset || abort) begin
            state        <= S_IDLE;
            n_lat        <= '0;
            mode_lat     <= 1'b0;
            sample_count <= '0;
            prev_ch0     <= '0;
            prev_ok      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else if (start_arm) begin
            // arm outranks rd_start in DONE; the old buffer is simply overwritten
            n_lat        <= n_clamp;
            mode_lat     <= trig_mode;
            sample_count <= '0;
            prev_ok      <= 1'b0;
            state        <= S_ARMED;
            busy         <= 1'b1;
            done         <= 1'b0;
        end else begin
            case (state)
                S_ARMED: begin
                    if (sample_stb && mode_lat) begin
                        prev_ch0 <= ch0;
                        prev_ok  <= 1'b1;
                    end
                    if (first_wr) begin
                        sample_count <= CNT_ONE;
                        if (n_lat == CNT_ONE) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (sample_stb) begin
                        sample_count <= cnt_inc;
                        if (cnt_inc == n_lat) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (rd_start) begin
                        state <= S_READOUT;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                S_READOUT: begin
                    if (finish) begin
                        state        <= S_IDLE;
                        sample_count <= '0;
                        busy         <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the sample RAM has no reset; clearing it would prevent block-RAM inference and every
    // slot that is ever read was written during the same capture.
    always_ff @(posedge sysclk) begin
        if (wr_en) mem[wr_addr] <= sample_in;
        if (rd_en) rd_word <= mem[rd_ptr[ADDR_W-1:0]];
    end

    // Two-word buffer (cur + nxt) plus one read in flight hides the RAM latency at full rate.
    assign hs       = cur_valid && rd.out_ready;
    assign word_pop = hs && (cur_ch == LAST_CH);
    assign finish   = word_pop && cur_last;
    assign flush    = reset || abort || (state != S_READOUT) || finish;
    assign occ_next = 2'(cur_valid) + 2'(nxt_valid) + 2'(rd_pend) - 2'(word_pop);
    assign rd_en    = !flush && (rd_ptr != n_lat) && (occ_next < 2'd2);

    always_ff @(posedge sysclk) begin
        if (flush) begin
            cur_valid <= 1'b0;
            nxt_valid <= 1'b0;
            cur_last  <= 1'b0;
            cur_ch    <= '0;
            cur_word  <= '0;
            rd_pend   <= 1'b0;
            rd_ptr    <= '0;
        end else begin
            rd_pend <= rd_en;
            if (rd_en) begin
                rd_ptr    <= rd_ptr + CNT_ONE;
                rd_last_q <= (rd_ptr == n_lat - CNT_ONE);
            end
            if (hs) cur_ch <= word_pop ? '0 : cur_ch + CH_W'(1);
            if (!cur_valid || word_pop) begin
                if (nxt_valid) begin
                    cur_word  <= nxt_word;
                    cur_last  <= nxt_last;
                    cur_valid <= 1'b1;
                    nxt_valid <= rd_pend;
                    if (rd_pend) begin
                        nxt_word <= rd_word;
                        nxt_last <= rd_last_q;
                    end
                end else if (rd_pend) begin
                    cur_word  <= rd_word;
                    cur_last  <= rd_last_q;
                    cur_valid <= 1'b1;
                end else begin
                    cur_valid <= 1'b0;
                end
            end else if (rd_pend) begin
                nxt_word  <= rd_word;
                nxt_last  <= rd_last_q;
                nxt_valid <= 1'b1;
            end
        end
    end

    assign rd.out_valid = cur_valid;
    assign rd.out_data  = cur_word[cur_ch];
    assign rd.out_ch    = cur_ch;
    assign rd.out_last  = cur_valid && cur_last && (cur_ch == LAST_CH);

endmodule

// File: tb/tb_dds_sample_recorder.sv
// Directed bench for dds_sample_recorder: capture modes, triggering, depth clamp, stalled readout,
// abort and input-priority corners, each with hand-computed expected beats.
module tb_dds_sample_recorder;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        sample_stb;
    logic [23:0] sample_in;
    logic        arm;
    logic        abort;
    logic        trig_mode;
    logic [10:0] n_samples;
    logic        rd_start;
    logic        busy;
    logic        done;
    logic [10:0] sample_count;

    int checks   = 0;
    int failures = 0;

    logic [11:0] exp_data[$];
    logic        exp_ch[$];
    logic [11:0] got_data[$];
    logic        got_ch[$];
    logic        got_last[$];
    int          stall_err;
    bit          timed_out;
    int          first_bad;

    dds_sample_recorder_if #(.SAMPLE_W(12), .CH_W(1)) rd_if ();

    dds_sample_recorder #(
        .SAMPLE_W(12), .N_CH(2), .DEPTH(1024), .ADDR_W(10), .TRIG_LEVEL(2048)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .sample_stb   (sample_stb),
        .sample_in    (sample_in),
        .arm          (arm),
        .abort        (abort),
        .trig_mode    (trig_mode),
        .n_samples    (n_samples),
        .rd_start     (rd_start),
        .rd           (rd_if),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 1000000");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic strobe(input logic [11:0] c0, input logic [11:0] c1, input int gap);
        sample_in  = {c1, c0};
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        if (gap > 1) tick(gap - 1);
    endtask

    task automatic arm_cap(input logic mode, input logic [10:0] n);
        trig_mode = mode;
        n_samples = n;
        arm       = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_rd_start();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        rd_if.out_ready = 1'b0;
        tick();
        abort = 1'b0;
    endtask

    task automatic expect_word(input logic [11:0] c0, input logic [11:0] c1);
        exp_data.push_back(c0);
        exp_ch.push_back(1'b0);
        exp_data.push_back(c1);
        exp_ch.push_back(1'b1);
    endtask

    // Drives out_ready (always 1, or an LFSR pattern) and records every accepted beat.
    task automatic run_readout(input bit use_pattern, input int budget);
        logic [7:0]  lfsr = 8'hA5;
        bit          r;
        bit          prev_stall = 1'b0;
        bit          fin = 1'b0;
        logic [11:0] pd = '0;
        logic        pch = 1'b0;
        logic        pl = 1'b0;
        got_data.delete();
        got_ch.delete();
        got_last.delete();
        stall_err = 0;
        for (int c = 0; c < budget && !fin; c++) begin
            if (use_pattern) begin
                lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                r    = lfsr[0];
            end else begin
                r = 1'b1;
            end
            rd_if.out_ready = r;
            if (prev_stall && (rd_if.out_valid !== 1'b1 || rd_if.out_data !== pd ||
                               rd_if.out_ch !== pch || rd_if.out_last !== pl))
                stall_err++;
            if (rd_if.out_valid === 1'b1 && r) begin
                got_data.push_back(rd_if.out_data);
                got_ch.push_back(rd_if.out_ch);
                got_last.push_back(rd_if.out_last);
                if (rd_if.out_last === 1'b1) fin = 1'b1;
            end
            prev_stall = (rd_if.out_valid === 1'b1) && !r;
            pd  = rd_if.out_data;
            pch = rd_if.out_ch;
            pl  = rd_if.out_last;
            tick();
        end
        rd_if.out_ready = 1'b0;
        timed_out = !fin;
    endtask

    function automatic int beat_errors();
        int e = 0;
        first_bad = -1;
        if (got_data.size() != exp_data.size()) begin
            e++;
            first_bad = got_data.size();
        end
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            if (got_data[i] !== exp_data[i] || got_ch[i] !== exp_ch[i] ||
                got_last[i] !== (i == exp_data.size() - 1)) begin
                e++;
                if (first_bad < 0) first_bad = i;
            end
        end
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1; arm = 1'b1; sample_stb = 1'b1; rd_start = 1'b1; rd_if.out_ready = 1'b1;
        sample_in = 24'hABC123; n_samples = 11'd4;
        tick(3);
        reset = 1'b0; arm = 1'b0; sample_stb = 1'b0; rd_start = 1'b0; rd_if.out_ready = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (sample_count !== 11'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", sample_count); end
        checks++; if (rd_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rd_if.out_valid); end
        checks++; if (rd_if.out_data !== 12'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", rd_if.out_data); end
        checks++; if (rd_if.out_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%0b exp=0", rd_if.out_last); end
    endtask

    task automatic test_mode0();
        int lat;
        int e;
        exp_data.delete(); exp_ch.delete();
        arm_cap(1'b0, 11'd4);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL m0_armed_busy got=%0b exp=1", busy); end
        for (int i = 0; i < 4; i++) begin
            strobe(12'(10 + i), 12'(110 + i), 100);
            expect_word(12'(10 + i), 12'(110 + i));
            if (i == 2) begin
                checks++; if (sample_count !== 11'd3 || done !== 1'b0) begin failures++; $display("FAIL m0_mid count=%0d done=%0b exp 3/0", sample_count, done); end
            end
        end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL m0_done done=%0b busy=%0b exp 1/0", done, busy); end
        checks++; if (sample_count !== 11'd4) begin failures++; $display("FAIL m0_count got=%0d exp=4", sample_count); end
        pulse_rd_start();
        lat = 0;
        while (rd_if.out_valid !== 1'b1 && lat < 6) begin tick(); lat++; end
        checks++; if (lat > 3) begin failures++; $display("FAIL m0_latency got=%0d cycles exp<=3", lat); end
        run_readout(1'b0, 100);
        e = beat_errors();
        checks++; if (timed_out) begin failures++; $display("FAIL m0_timeout beats=%0d exp=8", got_data.size()); end
        checks++; if (e != 0) begin failures++; $display("FAIL m0_beats errors=%0d first_bad=%0d exp errors=0", e, first_bad); end
        checks++; if (done !== 1'b0 || busy !== 1'b0 || sample_count !== 11'd0 || rd_if.out_valid !== 1'b0) begin
            failures++; $display("FAIL m0_after done=%0b busy=%0b count=%0d valid=%0b exp all 0", done, busy, sample_count, rd_if.out_valid); end
    endtask

    task automatic test_trigger();
        int e;
        exp_data.delete(); exp_ch.delete();
        arm_cap(1'b1, 11'd2);
        strobe(12'd2000, 12'd5, 3);
        strobe(12'd2047, 12'd6, 3);
        checks++; if (sample_count !== 11'd0 || busy !== 1'b1) begin failures++; $display("FAIL trig_premature count=%0d busy=%0b exp 0/1", sample_count, busy); end
        strobe(12'd2048, 12'd7, 3);
        checks++; if (sample_count !== 11'd1) begin failures++; $display("FAIL trig_hit count=%0d exp=1", sample_count); end
        strobe(12'd2100, 12'd8, 3);
        expect_word(12'd2048, 12'd7);
        expect_word(12'd2100, 12'd8);
        checks++; if (done !== 1'b1 || sample_count !== 11'd2) begin failures++; $display("FAIL trig_done done=%0b count=%0d exp 1/2", done, sample_count); end
        pulse_rd_start();
        run_readout(1'b0, 50);
        e = beat_errors();
        checks++; if (e != 0 || timed_out) begin failures++; $display("FAIL trig_beats errors=%0d timeout=%0b first_bad=%0d exp 0/0", e, timed_out, first_bad); end

        exp_data.delete(); exp_ch.delete();
        arm_cap(1'b1, 11'd2);
        strobe(12'd3000, 12'd1, 3);
        strobe(12'd3100, 12'd2, 3);
        strobe(12'd100, 12'd3, 3);
        checks++; if (sample_count !== 11'd0) begin failures++; $display("FAIL trig_high_start count=%0d exp=0", sample_count); end
        strobe(12'd2500, 12'd4, 3);
        strobe(12'd2600, 12'd9, 3);
        expect_word(12'd2500, 12'd4);
        expect_word(12'd2600, 12'd9);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL trig2_done got=%0b exp=1", done); end
        pulse_rd_start();
        run_readout(1'b0, 50);
        e = beat_errors();
        checks++; if (e != 0 || timed_out) begin failures++; $display("FAIL trig2_beats errors=%0d timeout=%0b first_bad=%0d exp 0/0", e, timed_out, first_bad); end
    endtask

    task automatic test_single();
        int e;
        exp_data.delete(); exp_ch.delete();
        arm_cap(1'b0, 11'd1);
        strobe(12'd5, 12'd6, 2);
        expect_word(12'd5, 12'd6);
        checks++; if (done !== 1'b1 || sample_count !== 11'd1) begin failures++; $display("FAIL n1_done done=%0b count=%0d exp 1/1", done, sample_count); end
        pulse_rd_start();
        run_readout(1'b0, 50);
        e = beat_errors();
        checks++; if (e != 0 || timed_out) begin failures++; $display("FAIL n1_beats errors=%0d timeout=%0b first_bad=%0d exp 0/0", e, timed_out, first_bad); end
    endtask

    task automatic test_stall();
        int e;
        exp_data.delete(); exp_ch.delete();
        arm_cap(1'b0, 11'd6);
        for (int i = 0; i < 6; i++) begin
            strobe(12'(100 * i + 7), 12'(4000 - 3 * i), 2);
            expect_word(12'(100 * i + 7), 12'(4000 - 3 * i));
        end
        pulse_rd_start();
        run_readout(1'b1, 300);
        e = beat_errors();
        checks++; if (timed_out) begin failures++; $display("FAIL stall_timeout beats=%0d exp=12", got_data.size()); end
        checks++; if (stall_err != 0) begin failures++; $display("FAIL stall_hold changes=%0d exp=0", stall_err); end
        checks++; if (e != 0) begin failures++; $display("FAIL stall_beats errors=%0d first_bad=%0d exp=0", e, first_bad); end
    endtask

    task automatic test_corner();
        int e;
        exp_data.delete(); exp_ch.delete();
        trig_mode = 1'b0; n_samples = 11'd2; arm = 1'b1; sample_stb = 1'b1; sample_in = {12'd777, 12'd77};
        tick();
        arm = 1'b0; sample_stb = 1'b0;
        tick(2);
        checks++; if (sample_count !== 11'd0 || busy !== 1'b1) begin failures++; $display("FAIL arm_stb count=%0d busy=%0b exp 0/1", sample_count, busy); end
        strobe(12'd88, 12'd888, 3);
        pulse_rd_start();
        tick(3);
        checks++; if (rd_if.out_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || sample_count !== 11'd1) begin
            failures++; $display("FAIL rdstart_capture valid=%0b busy=%0b done=%0b count=%0d exp 0/1/0/1", rd_if.out_valid, busy, done, sample_count); end
        strobe(12'd99, 12'd999, 3);
        strobe(12'd5, 12'd5, 3);
        expect_word(12'd88, 12'd888);
        expect_word(12'd99, 12'd999);
        checks++; if (done !== 1'b1 || sample_count !== 11'd2) begin failures++; $display("FAIL stb_in_done done=%0b count=%0d exp 1/2", done, sample_count); end
        pulse_rd_start();
        run_readout(1'b0, 50);
        e = beat_errors();
        checks++; if (e != 0 || timed_out) begin failures++; $display("FAIL corner_beats errors=%0d timeout=%0b first_bad=%0d exp 0/0", e, timed_out, first_bad); end

        arm_cap(1'b0, 11'd1);
        strobe(12'd1, 12'd2, 2);
        trig_mode = 1'b0; n_samples = 11'd3; arm = 1'b1; rd_start = 1'b1;
        tick();
        arm = 1'b0; rd_start = 1'b0;
        tick(3);
        checks++; if (busy !== 1'b1 || done !== 1'b0 || sample_count !== 11'd0 || rd_if.out_valid !== 1'b0) begin
            failures++; $display("FAIL arm_vs_rdstart busy=%0b done=%0b count=%0d valid=%0b exp 1/0/0/0", busy, done, sample_count, rd_if.out_valid); end
        pulse_abort();
    endtask

    task automatic test_abort();
        int  e;
        bit  seen;
        exp_data.delete(); exp_ch.delete();
        arm_cap(1'b0, 11'd8);
        for (int i = 1; i <= 3; i++) strobe(12'(i), 12'(i + 40), 2);
        checks++; if (sample_count !== 11'd3) begin failures++; $display("FAIL abort_pre count=%0d exp=3", sample_count); end
        pulse_abort();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || sample_count !== 11'd0 || rd_if.out_valid !== 1'b0) begin
            failures++; $display("FAIL abort_capture busy=%0b done=%0b count=%0d valid=%0b exp all 0", busy, done, sample_count, rd_if.out_valid); end
        pulse_rd_start();
        tick(4);
        checks++; if (rd_if.out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_rdstart valid=%0b busy=%0b exp 0/0", rd_if.out_valid, busy); end

        arm_cap(1'b0, 11'd3);
        strobe(12'd50, 12'd60, 2);
        strobe(12'd51, 12'd61, 2);
        strobe(12'd52, 12'd62, 2);
        checks++; if (done !== 1'b1 || sample_count !== 11'd3) begin failures++; $display("FAIL rearm_done done=%0b count=%0d exp 1/3", done, sample_count); end
        pulse_rd_start();
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            if (rd_if.out_valid === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++; if (!seen) begin failures++; $display("FAIL abort_rd_wait valid=%0b exp=1 within 6 cycles", rd_if.out_valid); end
        rd_if.out_ready = 1'b1;
        tick(2);
        pulse_abort();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || sample_count !== 11'd0 || rd_if.out_valid !== 1'b0) begin
            failures++; $display("FAIL abort_readout busy=%0b done=%0b count=%0d valid=%0b exp all 0", busy, done, sample_count, rd_if.out_valid); end
        pulse_rd_start();
        tick(4);
        checks++; if (rd_if.out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_rdstart2 valid=%0b busy=%0b exp 0/0", rd_if.out_valid, busy); end

        arm_cap(1'b0, 11'd2);
        strobe(12'd7, 12'd70, 2);
        strobe(12'd8, 12'd80, 2);
        expect_word(12'd7, 12'd70);
        expect_word(12'd8, 12'd80);
        pulse_rd_start();
        run_readout(1'b0, 50);
        e = beat_errors();
        checks++; if (e != 0 || timed_out) begin failures++; $display("FAIL abort_fresh errors=%0d timeout=%0b first_bad=%0d exp 0/0", e, timed_out, first_bad); end
    endtask

    task automatic test_full_depth();
        int e;
        exp_data.delete(); exp_ch.delete();
        arm_cap(1'b0, 11'd0);
        for (int i = 0; i < 1024; i++) begin
            strobe(12'(i), 12'(4095 - i), 2);
            expect_word(12'(i), 12'(4095 - i));
        end
        checks++; if (done !== 1'b1 || sample_count !== 11'd1024) begin failures++; $display("FAIL depth_done done=%0b count=%0d exp 1/1024", done, sample_count); end
        strobe(12'd1, 12'd1, 2);
        strobe(12'd2, 12'd2, 2);
        checks++; if (sample_count !== 11'd1024) begin failures++; $display("FAIL depth_overrun count=%0d exp=1024", sample_count); end
        pulse_rd_start();
        run_readout(1'b0, 3000);
        e = beat_errors();
        checks++; if (got_data.size() != 2048 || timed_out) begin failures++; $display("FAIL depth_beat_count got=%0d exp=2048", got_data.size()); end
        checks++; if (e != 0) begin failures++; $display("FAIL depth_beats errors=%0d first_bad=%0d exp=0", e, first_bad); end

        arm_cap(1'b0, 11'd1500);
        for (int i = 0; i < 1023; i++) strobe(12'(i), 12'(i), 2);
        checks++; if (done !== 1'b0 || sample_count !== 11'd1023) begin failures++; $display("FAIL clamp_pre done=%0b count=%0d exp 0/1023", done, sample_count); end
        strobe(12'd9, 12'd9, 2);
        checks++; if (done !== 1'b1 || sample_count !== 11'd1024) begin failures++; $display("FAIL clamp_done done=%0b count=%0d exp 1/1024", done, sample_count); end
        pulse_abort();
    endtask

    initial begin
        reset = 1'b1; sample_stb = 1'b0; sample_in = '0; arm = 1'b0; abort = 1'b0;
        trig_mode = 1'b0; n_samples = '0; rd_start = 1'b0; rd_if.out_ready = 1'b0;
        test_reset();
        test_mode0();
        test_trigger();
        test_single();
        test_stall();
        test_corner();
        test_abort();
        test_full_depth();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
